// File: rtl/mips_pkg.sv
// mips_pkg: shared types and widths for the MIPS pipeline memory stage.
//   mem_state_e : data-memory controller FSM states (IDLE, LO, HI, DONE)
//   DEST_W      : destination register index width
//   WORD_W      : datapath word width
package mips_pkg;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_e;
   localparam int DEST_W = 4;
   localparam int WORD_W = 32;
endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// mem_stage_sram_ctrl_if: halfword SRAM bus.
//   sram_addr   : halfword address (controller -> SRAM)
//   sram_dq_out : write data       (controller -> SRAM)
//   sram_we_n   : active-low write (controller -> SRAM)
//   sram_dq_in  : read data        (SRAM -> controller)
interface mem_stage_sram_ctrl_if #(parameter int SRAM_AW = 18);
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_out;
   logic [15:0]        sram_dq_in;
   logic               sram_we_n;
   modport master (output sram_addr, sram_dq_out, sram_we_n, input sram_dq_in);
   modport slave  (input sram_addr, sram_dq_out, sram_we_n, output sram_dq_in);
endinterface

// File: rtl/wait_counter.sv
// wait_counter: wait-state counter with terminal-count flag, for wait-stated peripherals.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : reload the start value
//   en       : advance one step; reloads the start value after the terminal count
//   cnt, tc  : current count, terminal-count flag
// DOWN=0 counts 0..TERM, DOWN=1 counts TERM..0.
module wait_counter #(
   parameter int           W    = 4,
   parameter logic [W-1:0] TERM = '1,
   parameter bit           DOWN = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);
   localparam logic [W-1:0] START = DOWN ? TERM : '0;
   localparam logic [W-1:0] LAST  = DOWN ? '0 : TERM;
   assign tc = cnt == LAST;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= START;
      else if (clr) cnt <= START;
      else if (en) cnt <= tc ? START : DOWN ? cnt - 1'b1 : cnt + 1'b1;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage data memory controller on a 16-bit wait-stated SRAM.
//   clk, rst                       : clock, asynchronous active-low reset
//   WB_en_in .. Dest_in            : EX/MEM register outputs
//   WB_en, MEM_R_en, ALU_result,
//   Dest, Mem_read_value           : MEM/WB register inputs
//   freeze                         : stalls every pipeline register during an access
//   sram                           : halfword SRAM bus (master side)
// A word access is a LO halfword then a HI halfword, each held WAIT_CYCLES cycles.
module mem_stage_sram_ctrl
   import mips_pkg::*;
#(
   parameter int WAIT_CYCLES = 4,
   parameter int SRAM_AW     = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_en_in,
   input  logic              MEM_R_en_in,
   input  logic              MEM_W_en_in,
   input  logic [WORD_W-1:0] ALU_result_in,
   input  logic [WORD_W-1:0] ST_val_in,
   input  logic [DEST_W-1:0] Dest_in,
   output logic              WB_en,
   output logic              MEM_R_en,
   output logic [WORD_W-1:0] ALU_result,
   output logic [DEST_W-1:0] Dest,
   output logic [WORD_W-1:0] Mem_read_value,
   output logic              freeze,
   mem_stage_sram_ctrl_if.master sram
);
   mem_state_e        state, state_nx;
   logic [3:0]        wcnt, wcnt_nx;
   logic              tc, req, busy, op_wr, op_wr_nx, we_n_nx;
   logic [WORD_W-1:0] rdata;

   assign req            = MEM_R_en_in | MEM_W_en_in;
   assign busy           = state == LO || state == HI;
   assign WB_en          = WB_en_in;
   assign MEM_R_en       = MEM_R_en_in;
   assign ALU_result     = ALU_result_in;
   assign Dest           = Dest_in;
   assign Mem_read_value = rdata;
   assign freeze         = rst & ((state == IDLE & req) | busy);

   wait_counter #(.W(4), .TERM(4'(WAIT_CYCLES - 1))) u_wcnt (
      .clk(clk), .rst(rst), .clr(state == IDLE), .en(busy), .cnt(wcnt), .tc(tc)
   );

   // DONE always returns to IDLE, so a request still held on the inputs
   // cannot restart the access it just completed.
   // The write strobe is registered, so it is derived from next-cycle state/count.
   always_comb begin
      state_nx = state == IDLE ? (req ? LO : IDLE) :
                 state == LO   ? (tc ? HI : LO) :
                 state == HI   ? (tc ? DONE : HI) : IDLE;
      op_wr_nx = (state == IDLE && req) ? MEM_W_en_in & ~MEM_R_en_in : op_wr;
      wcnt_nx  = (state == IDLE || tc) ? 4'd0 : wcnt + 4'd1;
      we_n_nx  = !(op_wr_nx && (state_nx == LO || state_nx == HI) && wcnt_nx < 4'(WAIT_CYCLES - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         op_wr            <= 1'b0;
         rdata            <= '0;
         sram.sram_addr   <= '0;
         sram.sram_dq_out <= '0;
         sram.sram_we_n   <= 1'b1;
      end else begin
         state            <= state_nx;
         op_wr            <= op_wr_nx;
         sram.sram_we_n   <= we_n_nx;
         sram.sram_dq_out <= state_nx == HI ? ST_val_in[31:16] : state_nx == LO ? ST_val_in[15:0] : '0;
         if (state == IDLE && req) sram.sram_addr <= {ALU_result_in[SRAM_AW:2], 1'b0};
         else if (state == LO && tc) sram.sram_addr[0] <= 1'b1;
         if (state == LO && tc && !op_wr) rdata[15:0] <= sram.sram_dq_in;
         if (state == HI && tc && !op_wr) rdata[31:16] <= sram.sram_dq_in;
      end
   end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed bench; u_dut0 runs WAIT_CYCLES=4, u_dut1 runs WAIT_CYCLES=1.
module tb_mem_stage_sram_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        WB_en_in, MEM_R_en_in, MEM_W_en_in;
   logic [31:0] ALU_result_in, ST_val_in;
   logic [3:0]  Dest_in;
   logic        WB_en0, MEM_R_en0, freeze0, WB_en1, MEM_R_en1, freeze1;
   logic [31:0] ALU_result0, Mem_read_value0, ALU_result1, Mem_read_value1;
   logic [3:0]  Dest0, Dest1;
   int          n_cmp = 0, n_err = 0;
   int          nf, nlo, nhi, nother;

   mem_stage_sram_ctrl_if #(.SRAM_AW(18)) sif0 ();
   mem_stage_sram_ctrl_if #(.SRAM_AW(18)) sif1 ();

   mem_stage_sram_ctrl #(.WAIT_CYCLES(4), .SRAM_AW(18)) u_dut0 (
      .clk(clk), .rst(rst), .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in),
      .MEM_W_en_in(MEM_W_en_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
      .Dest_in(Dest_in), .WB_en(WB_en0), .MEM_R_en(MEM_R_en0), .ALU_result(ALU_result0),
      .Dest(Dest0), .Mem_read_value(Mem_read_value0), .freeze(freeze0), .sram(sif0)
   );

   mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
      .clk(clk), .rst(rst), .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in),
      .MEM_W_en_in(MEM_W_en_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
      .Dest_in(Dest_in), .WB_en(WB_en1), .MEM_R_en(MEM_R_en1), .ALU_result(ALU_result1),
      .Dest(Dest1), .Mem_read_value(Mem_read_value1), .freeze(freeze1), .sram(sif1)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [17:0] a);
      case (a)
         18'h200: mem = 16'h5678;
         18'h201: mem = 16'h1234;
         18'h204: mem = 16'hCAFE;
         18'h205: mem = 16'hBABE;
         default: mem = 16'h0000;
      endcase
   endfunction

   always_comb sif0.sram_dq_in = mem(sif0.sram_addr);
   always_comb sif1.sram_dq_in = mem(sif1.sram_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Samples one cycle per iteration until freeze drops (DONE), tallying
   // freeze-high cycles and strobed cycles by halfword address/data.
   task automatic run_op(input bit sel);
      logic        f, we;
      logic [17:0] a;
      logic [15:0] d;
      nf = 0; nlo = 0; nhi = 0; nother = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         f  = sel ? freeze1 : freeze0;
         we = sel ? sif1.sram_we_n : sif0.sram_we_n;
         a  = sel ? sif1.sram_addr : sif0.sram_addr;
         d  = sel ? sif1.sram_dq_out : sif0.sram_dq_out;
         if (!f) break;
         nf++;
         if (!we) begin
            if (a == 18'h200 && d == ST_val_in[15:0]) nlo++;
            else if (a == 18'h201 && d == ST_val_in[31:16]) nhi++;
            else nother++;
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b0; WB_en_in = 1'b0; MEM_R_en_in = 1'b1; MEM_W_en_in = 1'b0;
      ALU_result_in = 32'h0; ST_val_in = 32'h0; Dest_in = 4'h0;
      step();
      chk("rst_freeze_forced", {31'd0, freeze0}, 32'd0);
      chk("rst_we_n", {31'd0, sif0.sram_we_n}, 32'd1);
      chk("rst_addr", {14'd0, sif0.sram_addr}, 32'd0);
      chk("rst_dq_out", {16'd0, sif0.sram_dq_out}, 32'd0);
      chk("rst_rdata", Mem_read_value0, 32'd0);
      MEM_R_en_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      // non-memory pass-through
      WB_en_in = 1'b1; ALU_result_in = 32'h7; Dest_in = 4'd5;
      #1;
      chk("pt_freeze", {31'd0, freeze0}, 32'd0);
      chk("pt_alu", ALU_result0, 32'h7);
      chk("pt_dest", {28'd0, Dest0}, 32'd5);
      chk("pt_wb", {31'd0, WB_en0}, 32'd1);
      chk("pt_mem_r", {31'd0, MEM_R_en0}, 32'd0);
      step();
      #1;
      chk("pt_we_n", {31'd0, sif0.sram_we_n}, 32'd1);
      chk("pt_freeze2", {31'd0, freeze0}, 32'd0);
      chk("pt_addr_idle", {14'd0, sif0.sram_addr}, 32'd0);
      // load 0x400 -> halfwords 0x200/0x201
      step();
      MEM_R_en_in = 1'b1; ALU_result_in = 32'h400; Dest_in = 4'd3;
      run_op(1'b0);
      chk("ld_freeze_cycles", nf, 32'd9);
      chk("ld_no_strobe", nlo + nhi + nother, 32'd0);
      chk("ld_done_freeze", {31'd0, freeze0}, 32'd0);
      chk("ld_data", Mem_read_value0, 32'h12345678);
      // back-to-back store starts the cycle after DONE
      MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b1; WB_en_in = 1'b0; ST_val_in = 32'hDEADBEEF;
      step();
      run_op(1'b0);
      chk("st_freeze_cycles", nf, 32'd9);
      chk("st_lo_strobes", nlo, 32'd3);
      chk("st_hi_strobes", nhi, 32'd3);
      chk("st_stray_strobes", nother, 32'd0);
      chk("st_keeps_rdata", Mem_read_value0, 32'h12345678);
      MEM_W_en_in = 1'b0;
      nf = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         if (freeze0 || !sif0.sram_we_n) nf++;
      end
      chk("no_third_access", nf, 32'd0);
      chk("addr_after_store", {14'd0, sif0.sram_addr}, 32'h201);
      // reset in the second HI cycle of a store
      MEM_W_en_in = 1'b1; ST_val_in = 32'h13572468; ALU_result_in = 32'h800;
      repeat (6) step();
      #1;
      chk("mid_we_n_low", {31'd0, sif0.sram_we_n}, 32'd0);
      rst = 1'b0;
      #1;
      chk("async_we_n", {31'd0, sif0.sram_we_n}, 32'd1);
      chk("async_freeze", {31'd0, freeze0}, 32'd0);
      chk("async_rdata", Mem_read_value0, 32'd0);
      MEM_W_en_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      #1;
      chk("post_rst_freeze", {31'd0, freeze0}, 32'd0);
      chk("post_rst_we_n", {31'd0, sif0.sram_we_n}, 32'd1);
      // address wrap: bits above SRAM_AW ignored, 0xFFF80408 -> 0x204/0x205
      step();
      MEM_R_en_in = 1'b1; ALU_result_in = 32'hFFF80408;
      run_op(1'b0);
      chk("wrap_freeze_cycles", nf, 32'd9);
      chk("wrap_data", Mem_read_value0, 32'hBABECAFE);
      MEM_R_en_in = 1'b0;
      repeat (6) step();
      // read wins over write, WAIT_CYCLES=1
      MEM_R_en_in = 1'b1; MEM_W_en_in = 1'b1; ALU_result_in = 32'h400; ST_val_in = 32'hFFFFFFFF;
      run_op(1'b1);
      chk("rw_freeze_cycles", nf, 32'd3);
      chk("rw_no_strobe", nlo + nhi + nother, 32'd0);
      chk("rw_done_freeze", {31'd0, freeze1}, 32'd0);
      chk("rw_data", Mem_read_value1, 32'h12345678);
      MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
